// File: rtl/ram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane write enables, 1/2-cycle registered read,
// selectable read-during-write policy and an optional post-reset zero-fill sequencer.
module ram_sdp_be #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                init_busy,
  input  logic                                we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be,
  input  logic [ADDR_WIDTH-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic                                re,
  input  logic [ADDR_WIDTH-1:0]               raddr,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic                                dout_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clearing;
  logic                    rd_en;
  logic [NB-1:0]           wr_lane_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   rd_raw_q;
  logic [NB-1:0]           byp_mask_q, byp_mask_d;
  logic [DATA_WIDTH-1:0]   byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    v1_q, v1_d;
  logic [DATA_WIDTH-1:0]   dout2_q, dout2_d;
  logic                    v2_q, v2_d;

  // Sequencer: CLEAR walks every address once, then READY until the next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == '1) state_d = READY;
        end else begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign init_busy = rst | (state_q == CLEAR);
  assign clearing  = ~rst & (state_q == CLEAR);
  assign rd_en     = re & ~init_busy;

  // The clear sequencer shares the single write port so the array stays one BRAM.
  always_comb begin
    wr_addr = clearing ? clr_cnt_q : waddr;
    wr_data = clearing ? '0 : din;
    for (int i = 0; i < NB; i++) begin
      wr_lane_en[i] = clearing | (~init_busy & we & be[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lane_en[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array read is read-first; write-first collisions are patched per lane after the BRAM.
  always_ff @(posedge clk) begin
    if (rst) rd_raw_q <= '0;
    else if (rd_en) rd_raw_q <= mem[raddr];
  end

  always_comb begin
    byp_mask_d = byp_mask_q;
    byp_data_d = byp_data_q;
    if (rd_en) begin
      byp_data_d = din;
      for (int i = 0; i < NB; i++) begin
        byp_mask_d[i] = (RDW_MODE == 1) & we & be[i] & (raddr == waddr);
      end
    end
    v1_d    = rd_en;
    dout2_d = v1_q ? rd_word : dout2_q;
    v2_d    = v1_q;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = byp_mask_q[gi]
        ? byp_data_q[gi*BYTE_WIDTH +: BYTE_WIDTH]
        : rd_raw_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
      v1_q       <= 1'b0;
      dout2_q    <= '0;
      v2_q       <= 1'b0;
    end else begin
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
      v1_q       <= v1_d;
      dout2_q    <= dout2_d;
      v2_q       <= v2_d;
    end
  end

  assign dout       = (READ_LATENCY == 2) ? dout2_q : rd_word;
  assign dout_valid = (READ_LATENCY == 2) ? v2_q : v1_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: three RAM instances (lat1/read-first/clear, lat2/write-first/clear,
// lat1/read-first/no-clear) share one stimulus stream and are checked against hand values.
module tb_ram_sdp_be;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  waddr;
  logic [31:0] din;
  logic        re;
  logic [3:0]  raddr;

  logic        busy0, busy1, busy2;
  logic [31:0] dout0, dout1, dout2;
  logic        dv0, dv1, dv2;

  int vectors;
  int miscompares;

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1),
               .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .init_busy(busy0), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout0), .dout_valid(dv0));

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2),
               .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .init_busy(busy1), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout1), .dout_valid(dv1));

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1),
               .RDW_MODE(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst), .init_busy(busy2), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout2), .dout_valid(dv2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; waddr = a; din = d; be = b;
    tick();
    $display("write addr=%0d be=%b din=%h", a, b, d);
    we = 1'b0; be = 4'h0;
  endtask

  // u0/u2 answer one cycle after the read edge, u1 one cycle later still.
  task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1,
                    input logic [31:0] e2, input bit c2);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
    chk("rd_v0", {31'd0, dv0}, 32'd1);
    chk("rd_d0", dout0, e0);
    chk("rd_v1_early", {31'd0, dv1}, 32'd0);
    if (c2) chk("rd_d2", dout2, e2);
    tick();
    chk("rd_v1", {31'd0, dv1}, 32'd1);
    chk("rd_d1", dout1, e1);
    $display("read addr=%0d dout0=%h dout1=%h dout2=%h", a, dout0, dout1, dout2);
  endtask

  initial begin
    int n;
    logic bad_v;
    logic [31:0] e;
    vectors = 0; miscompares = 0;
    rst = 1'b1; we = 1'b0; be = 4'h0; waddr = '0; din = '0; re = 1'b0; raddr = '0;

    // Reset held two cycles, then count clear cycles with write/read attempts pending.
    tick(); tick();
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_dv1", {31'd0, dv1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("noclr_busy_first", {31'd0, busy2}, 32'd0);
    chk("clr_busy_first", {31'd0, busy0}, 32'd1);
    we = 1'b1; be = 4'hF; waddr = 4'd2; din = 32'hDEADBEEF; re = 1'b1; raddr = 4'd2;
    n = 0; bad_v = 1'b0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      if (dv0 || dv1) bad_v = 1'b1;
    end
    we = 1'b0; re = 1'b0; be = 4'h0;
    $display("clear done after %0d cycles", n);
    chk("clr_cycles", n, 32'd16);
    chk("clr_no_dv", {31'd0, bad_v}, 32'd0);
    chk("clr_busy1_done", {31'd0, busy1}, 32'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, 32'd0, 32'd0, 1'b0);

    // Byte-lane merge and be=0 no-op.
    wr(4'd3, 32'h11223344, 4'hF);
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    rd(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);
    wr(4'd3, 32'h00000000, 4'h0);
    rd(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);

    // Back-to-back reads: latency 1 valid on cycles 1..4, latency 2 on cycles 2..5.
    for (int a = 0; a < 4; a++) wr(4'(a), 32'hA0 + 32'(a), 4'hF);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin re = 1'b1; raddr = 4'(k); end
      else re = 1'b0;
      tick();
      $display("lat k=%0d dv0=%b dout0=%h dv1=%b dout1=%h", k, dv0, dout0, dv1, dout1);
      chk("lat_v0", {31'd0, dv0}, (k < 4) ? 32'd1 : 32'd0);
      e = 32'hA0 + ((k < 4) ? 32'(k) : 32'd3);
      chk("lat_d0", dout0, e);
      chk("lat_d2", dout2, e);
      chk("lat_v1", {31'd0, dv1}, (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      if (k >= 1) chk("lat_d1", dout1, 32'hA0 + ((k - 1 < 3) ? 32'(k - 1) : 32'd3));
    end
    re = 1'b0;

    // Same-address read and partial write on one edge.
    wr(4'd5, 32'h01020304, 4'hF);
    we = 1'b1; be = 4'b1100; din = 32'hFFFFFFFF; waddr = 4'd5; re = 1'b1; raddr = 4'd5;
    tick();
    we = 1'b0; be = 4'h0; re = 1'b0;
    chk("coll_v0", {31'd0, dv0}, 32'd1);
    chk("coll_rf_d0", dout0, 32'h01020304);
    chk("coll_rf_d2", dout2, 32'h01020304);
    tick();
    chk("coll_v1", {31'd0, dv1}, 32'd1);
    chk("coll_wf_d1", dout1, 32'hFFFF0304);
    $display("collision dout0=%h dout1=%h", dout0, dout1);
    rd(4'd5, 32'hFFFF0304, 32'hFFFF0304, 32'hFFFF0304, 1'b1);

    // Reset lands while a latency-2 read is in flight.
    re = 1'b1; raddr = 4'd5;
    tick();
    re = 1'b0; rst = 1'b1;
    tick();
    $display("inflight reset dv1=%b dout1=%h", dv1, dout1);
    chk("inflight_dv1", {31'd0, dv1}, 32'd0);
    chk("inflight_dout1", dout1, 32'd0);
    chk("inflight_dout0", dout0, 32'd0);
    chk("inflight_busy1", {31'd0, busy1}, 32'd1);
    rst = 1'b0;

    // Reset again at clear cycle 7: a full 16-cycle clear follows.
    bad_v = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (dv1) bad_v = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      if (dv1) bad_v = 1'b1;
    end
    $display("restarted clear done after %0d cycles", n);
    chk("reclr_cycles", n, 32'd16);
    chk("reclr_no_dv1", {31'd0, bad_v}, 32'd0);
    rd(4'd3, 32'd0, 32'd0, 32'h000000A3, 1'b1);

    // Plain write/read after everything settles.
    wr(4'd9, 32'hDEADBEEF, 4'hF);
    rd(4'd9, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
